// File: rtl/riscv_core_mdu_divider.sv
// riscv_core_mdu_divider
// Iterative radix-2 restoring divider for the RISC-V M extension: DIV, DIVU, REM, REMU
// and, when DATA_WIDTH is 64, the W-variants (32-bit operands, sign-extended result).
// One operation is in flight at a time; o_valid pulses for one cycle with the result.
// Optional macro RISCV_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish
// straight from PREP with the forced result instead of running the full iteration.

module riscv_core_mdu_divider #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [1:0]            i_op,
    input  logic                  i_word,
    input  logic [DATA_WIDTH-1:0] i_dividend,
    input  logic [DATA_WIDTH-1:0] i_divisor,
    input  logic                  i_flush,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] WORD_COUNT = CW'(32);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic            word_q, word_d;
    logic [W-1:0]    dividend_q, dividend_d;
    logic [W-1:0]    divisor_q, divisor_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W:0]      rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            quoNeg_q, quoNeg_d;
    logic            remNeg_q, remNeg_d;
    logic            divZero_q, divZero_d;
    logic            overflow_q, overflow_d;
    logic [W-1:0]    result_q, result_d;

    logic            isSigned;
    logic [W-1:0]    extDividend, extDivisor, minValue;
    logic            signA, signB;
    logic [W-1:0]    absDividend, absDivisor, quoInit;
    logic            prepDivZero, prepOverflow;
    logic [W+1:0]    shifted, trial;
    logic [W-1:0]    quoSigned, remSigned, fixQuo, fixRem;

    // Picks quotient or remainder and, for W-ops, sign-extends bit 31 over the upper half.
    function automatic logic [W-1:0] selectResult(input logic isRem, input logic isWord,
                                                  input logic [W-1:0] quotient,
                                                  input logic [W-1:0] remainder);
        logic [W-1:0] sel;
        sel = isRem ? remainder : quotient;
        if (isWord) begin
            for (int i = 32; i < W; i++) sel[i] = sel[31];
        end
        return sel;
    endfunction

    // Datapath helpers: operand conditioning for PREP, one restoring step for CALC, sign fix for FIX.
    always_comb begin
        isSigned    = ~op_q[0];
        extDividend = dividend_q;
        extDivisor  = divisor_q;
        minValue    = '0;
        minValue[W-1] = 1'b1;
        if (word_q) begin
            for (int i = 32; i < W; i++) begin
                extDividend[i] = isSigned & dividend_q[31];
                extDivisor[i]  = isSigned & divisor_q[31];
            end
            for (int i = 31; i < W; i++) minValue[i] = 1'b1;
        end
        signA        = isSigned & extDividend[W-1];
        signB        = isSigned & extDivisor[W-1];
        absDividend  = signA ? -extDividend : extDividend;
        absDivisor   = signB ? -extDivisor : extDivisor;
        quoInit      = word_q ? (absDividend << 32) : absDividend;
        prepDivZero  = (extDivisor == '0);
        prepOverflow = isSigned && (extDividend == minValue) && (extDivisor == '1);

        shifted = {rem_q, quo_q[W-1]};
        trial   = shifted - {2'b00, divisor_q};

        quoSigned = quoNeg_q ? -quo_q : quo_q;
        remSigned = remNeg_q ? -rem_q[W-1:0] : rem_q[W-1:0];
        fixQuo    = quoSigned;
        fixRem    = remSigned;
        if (divZero_q) begin
            fixQuo = '1;
            fixRem = dividend_q;
        end else if (overflow_q) begin
            fixQuo = dividend_q;
            fixRem = '0;
        end
    end

    // Next-state logic for the IDLE/PREP/CALC/FIX/DONE sequence; a flush overrides everything.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        word_d     = word_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        quoNeg_d   = quoNeg_q;
        remNeg_d   = remNeg_q;
        divZero_d  = divZero_q;
        overflow_d = overflow_q;
        result_d   = result_q;

        case (state_q)
            S_IDLE: begin
                if (i_valid && !i_flush) begin
                    op_d       = i_op;
                    word_d     = i_word && (W == 64);
                    dividend_d = i_dividend;
                    divisor_d  = i_divisor;
                    state_d    = S_PREP;
                end
            end
            S_PREP: begin
                dividend_d = extDividend;
                divisor_d  = absDivisor;
                quo_d      = quoInit;
                rem_d      = '0;
                cnt_d      = word_q ? WORD_COUNT : FULL_COUNT;
                quoNeg_d   = signA ^ signB;
                remNeg_d   = signA;
                divZero_d  = prepDivZero;
                overflow_d = prepOverflow;
                state_d    = S_CALC;
`ifdef RISCV_DIV_EARLY_OUT_EN
                if (prepDivZero || prepOverflow) begin
                    result_d = selectResult(op_q[1], word_q,
                                            prepDivZero ? {W{1'b1}} : extDividend,
                                            prepDivZero ? extDividend : {W{1'b0}});
                    state_d  = S_DONE;
                end
`endif
            end
            S_CALC: begin
                if (!trial[W+1]) begin
                    rem_d = trial[W:0];
                    quo_d = {quo_q[W-2:0], 1'b1};
                end else begin
                    rem_d = shifted[W:0];
                    quo_d = {quo_q[W-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                result_d = selectResult(op_q[1], word_q, fixQuo, fixRem);
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (i_flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    // State and datapath registers; reset clears everything and aborts any operation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            word_q     <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            quoNeg_q   <= 1'b0;
            remNeg_q   <= 1'b0;
            divZero_q  <= 1'b0;
            overflow_q <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            word_q     <= word_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            quoNeg_q   <= quoNeg_d;
            remNeg_q   <= remNeg_d;
            divZero_q  <= divZero_d;
            overflow_q <= overflow_d;
            result_q   <= result_d;
        end
    end

    assign o_ready  = (state_q == S_IDLE);
    assign o_valid  = (state_q == S_DONE);
    assign o_result = result_q;

endmodule

// File: tb/tb_riscv_core_mdu_divider.sv
// tb_riscv_core_mdu_divider
// Self-checking bench for riscv_core_mdu_divider (DATA_WIDTH = 64): directed vector table,
// multi-cycle corner sequences (flush, busy requests, async reset) and random operations
// checked against a plain-arithmetic RISC-V division model.
// Honours RISCV_DIV_EARLY_OUT_EN when computing expected latencies.

module tb_riscv_core_mdu_divider;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_op;
    logic        i_word;
    logic [63:0] i_dividend;
    logic [63:0] i_divisor;
    logic        i_flush;
    logic        o_valid;
    logic [63:0] o_result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[16];

    riscv_core_mdu_divider #(.DATA_WIDTH(64)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_op       (i_op),
        .i_word     (i_word),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .i_flush    (i_flush),
        .o_valid    (o_valid),
        .o_result   (o_result)
    );

    // Free-running core clock, period 10.
    always #5 i_clk = ~i_clk;

    // Watchdog so the run always ends even if the design locks up.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    // RISC-V M-extension division semantics written with native arithmetic.
    function automatic logic [63:0] refModel(input logic [1:0] op, input logic word,
                                             input logic [63:0] a, input logic [63:0] b);
        logic            isRem, isSigned;
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        int              wa, wb, wq, wr;
        int unsigned     va, vb;
        logic [31:0]     w32;
        logic [63:0]     res;
        isRem    = op[1];
        isSigned = !op[0];
        if (word) begin
            wa = int'(a[31:0]);
            wb = int'(b[31:0]);
            va = a[31:0];
            vb = b[31:0];
            if (vb == 0) begin
                wq = -1;
                wr = wa;
            end else if (isSigned && wa == int'(32'h8000_0000) && wb == -1) begin
                wq = wa;
                wr = 0;
            end else if (isSigned) begin
                wq = wa / wb;
                wr = wa % wb;
            end else begin
                wq = int'(va / vb);
                wr = int'(va % vb);
            end
            w32 = isRem ? wr : wq;
            res = {{32{w32[31]}}, w32};
        end else begin
            sa = longint'(a);
            sb = longint'(b);
            ua = a;
            ub = b;
            if (ub == 0) begin
                sq = -1;
                sr = sa;
            end else if (isSigned && a == 64'h8000_0000_0000_0000 && sb == -1) begin
                sq = sa;
                sr = 0;
            end else if (isSigned) begin
                sq = sa / sb;
                sr = sa % sb;
            end else begin
                sq = longint'(ua / ub);
                sr = longint'(ua % ub);
            end
            res = isRem ? sr : sq;
        end
        return res;
    endfunction

    // Cycles from the accept cycle to the o_valid cycle.
    function automatic int expLat(input logic [1:0] op, input logic word,
                                  input logic [63:0] a, input logic [63:0] b);
        bit special;
        int n;
        n = word ? 32 : 64;
        if (word)
            special = (b[31:0] == 32'd0) ||
                      (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        else
            special = (b == 64'd0) ||
                      (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
`ifndef RISCV_DIV_EARLY_OUT_EN
        special = 1'b0;
`endif
        return special ? 2 : n + 3;
    endfunction

    // Drives one request at a negedge, holding i_valid until it is accepted.
    task automatic applyStimulus(input logic [1:0] op, input logic word,
                                 input logic [63:0] a, input logic [63:0] b);
        int waitCnt;
        waitCnt = 0;
        while (!o_ready && waitCnt < 200) begin
            @(negedge i_clk);
            waitCnt++;
        end
        if (!o_ready) checkOutput("readyTimeout", 64'(o_ready), 64'd1);
        i_valid    = 1'b1;
        i_op       = op;
        i_word     = word;
        i_dividend = a;
        i_divisor  = b;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    // Runs one operation end to end; returns result and latency, checks the pulse shape.
    task automatic runOp(input logic [1:0] op, input logic word, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] res, output int lat);
        applyStimulus(op, word, a, b);
        lat = 1;
        while (!o_valid && lat < 100) begin
            @(negedge i_clk);
            lat++;
        end
        if (!o_valid) checkOutput("validTimeout", 64'(o_valid), 64'd1);
        res = o_result;
        @(negedge i_clk);
        checkOutput("pulseLow", 64'(o_valid), 64'd0);
        checkOutput("readyAfterDone", 64'(o_ready), 64'd1);
    endtask

    // Counts o_valid pulses over a window of cycles.
    task automatic countValid(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge i_clk);
            if (o_valid) seen++;
        end
    endtask

    initial begin
        logic [63:0] res;
        int          lat;
        int          seen;
        logic [1:0]  rop;
        logic        rword;
        logic [63:0] ra, rb;

        vecs[0]  = '{"div_neg20_3",    OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,                   64'hFFFF_FFFF_FFFF_FFFA};
        vecs[1]  = '{"remu_max_10",    OP_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10,                  64'd5};
        vecs[2]  = '{"rem_neg20_3",    OP_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,                   64'hFFFF_FFFF_FFFF_FFFE};
        vecs[3]  = '{"divw_trunc",     OP_DIV,  1'b1, 64'h0000_0001_8000_0000, 64'd2,                   64'hFFFF_FFFF_C000_0000};
        vecs[4]  = '{"divu_by0",       OP_DIVU, 1'b0, 64'h0000_0000_0000_1234, 64'd0,                   64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5]  = '{"rem_7_by0",      OP_REM,  1'b0, 64'd7,                   64'd0,                   64'd7};
        vecs[6]  = '{"div_ovf",        OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        vecs[7]  = '{"rem_ovf",        OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        vecs[8]  = '{"divu_100_7",     OP_DIVU, 1'b0, 64'd100,                 64'd7,                   64'd14};
        vecs[9]  = '{"remuw_by0",      OP_REMU, 1'b1, 64'hFFFF_FFFF_0000_0007, 64'hABCD_0000_0000_0000, 64'd7};
        vecs[10] = '{"divw_ovf",       OP_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000};
        vecs[11] = '{"remw_neg7_2",    OP_REM,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFF};
        vecs[12] = '{"divuw_sext",     OP_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1,                   64'hFFFF_FFFF_FFFF_FFFF};
        vecs[13] = '{"div_7_neg2",     OP_DIV,  1'b0, 64'd7,                   64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[14] = '{"remu_big",       OP_REMU, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        vecs[15] = '{"divw_100_neg7",  OP_DIV,  1'b1, 64'h1234_5678_0000_0064, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2};

        i_rst_n    = 1'b0;
        i_valid    = 1'b0;
        i_op       = 2'b00;
        i_word     = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        i_flush    = 1'b0;

        repeat (2) @(negedge i_clk);
        checkOutput("resetReady", 64'(o_ready), 64'd1);
        checkOutput("resetValid", 64'(o_valid), 64'd0);
        checkOutput("resetResult", o_result, 64'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        $display("[TB] directed vector table");
        for (int i = 0; i < 16; i++) begin
            runOp(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, res, lat);
            checkOutput({vecs[i].name, "_result"}, res, vecs[i].exp);
            checkOutput({vecs[i].name, "_latency"}, 64'(lat),
                        64'(expLat(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b)));
        end

        $display("[TB] busy-time requests are ignored");
        applyStimulus(OP_DIVU, 1'b0, 64'd1000, 64'd3);
        lat = 1;
        i_valid    = 1'b1;
        i_op       = OP_DIV;
        i_dividend = 64'd5;
        i_divisor  = 64'd1;
        checkOutput("busyReady", 64'(o_ready), 64'd0);
        repeat (20) begin
            @(negedge i_clk);
            lat++;
        end
        i_valid = 1'b0;
        while (!o_valid && lat < 100) begin
            @(negedge i_clk);
            lat++;
        end
        checkOutput("busyResult", o_result, 64'd333);
        checkOutput("busyLatency", 64'(lat), 64'd67);
        @(negedge i_clk);
        checkOutput("busyReadyAfter", 64'(o_ready), 64'd1);

        $display("[TB] flush mid-calculation and flush in idle");
        runOp(OP_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, res, lat);
        checkOutput("preFlushResult", res, 64'd5);
        applyStimulus(OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3);
        repeat (10) @(negedge i_clk);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        checkOutput("flushReady", 64'(o_ready), 64'd1);
        checkOutput("flushValid", 64'(o_valid), 64'd0);
        checkOutput("flushResultHeld", o_result, 64'd5);
        i_valid    = 1'b1;
        i_flush    = 1'b1;
        i_op       = OP_DIVU;
        i_word     = 1'b0;
        i_dividend = 64'd9;
        i_divisor  = 64'd0;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_flush = 1'b0;
        checkOutput("flushWinsReady", 64'(o_ready), 64'd1);
        countValid(80, seen);
        checkOutput("flushNoValid", 64'(seen), 64'd0);
        checkOutput("flushResultStill", o_result, 64'd5);
        runOp(OP_DIVU, 1'b0, 64'd100, 64'd7, res, lat);
        checkOutput("postFlushResult", res, 64'd14);
        checkOutput("postFlushLatency", 64'(lat), 64'd67);

        $display("[TB] random operations against reference model");
        for (int i = 0; i < 24; i++) begin
            rop   = 2'($urandom_range(0, 3));
            rword = 1'($urandom_range(0, 1));
            ra    = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0:       rb = {$urandom, $urandom};
                1:       rb = 64'($urandom_range(1, 15));
                2:       rb = -64'($urandom_range(1, 15));
                3:       rb = {32'($urandom), 32'($urandom)} >> $urandom_range(0, 63);
                default: rb = {$urandom, 32'd0};
            endcase
            if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 63);
            runOp(rop, rword, ra, rb, res, lat);
            checkOutput($sformatf("rand%0d_result", i), res, refModel(rop, rword, ra, rb));
            checkOutput($sformatf("rand%0d_latency", i), 64'(lat), 64'(expLat(rop, rword, ra, rb)));
        end

        $display("[TB] async reset in the middle of an operation");
        applyStimulus(OP_DIV, 1'b0, 64'd123456789, 64'd7);
        repeat (15) @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("midResetReady", 64'(o_ready), 64'd1);
        checkOutput("midResetValid", 64'(o_valid), 64'd0);
        checkOutput("midResetResult", o_result, 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        countValid(80, seen);
        checkOutput("resetNoValid", 64'(seen), 64'd0);
        checkOutput("resetReadyAfter", 64'(o_ready), 64'd1);
        runOp(OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, res, lat);
        checkOutput("afterResetResult", res, 64'hFFFF_FFFF_FFFF_FFFA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
